// File: rtl/csr_pkg.sv
// Shared constants for the CSR register file: word addresses, CONTROL bit
// positions and the default block identifier.
package csr_pkg;

    localparam logic [31:0] ID_VALUE_DEFAULT = 32'h4143_524E;

    localparam int unsigned ADDR_ID          = 'h00;
    localparam int unsigned ADDR_CONTROL     = 'h01;
    localparam int unsigned ADDR_STATUS      = 'h02;
    localparam int unsigned ADDR_SCRATCH     = 'h03;
    localparam int unsigned ADDR_CYCLE_LO    = 'h04;
    localparam int unsigned ADDR_CYCLE_HI    = 'h05;
    localparam int unsigned ADDR_H2C_BEATS   = 'h06;
    localparam int unsigned ADDR_C2H_BEATS   = 'h07;
    localparam int unsigned ADDR_H2C_PACKETS = 'h08;
    localparam int unsigned ADDR_C2H_PACKETS = 'h09;

    localparam int unsigned CTRL_ENABLE_BIT  = 0;
    localparam int unsigned CTRL_SRESET_BIT  = 1;

endpackage

// File: rtl/csr_register_file_if.sv
// Bundle of the CSR access bus and the two stream monitor taps, with
// master (host/bench) and slave (register file) views.
interface csr_register_file_if #(
    parameter int CSR_DATA_WIDTH    = 32,
    parameter int CSR_ADDRESS_WIDTH = 8
);
    logic                         CSR_FF_valid;
    logic                         CSR_FF_write_enable;
    logic [CSR_ADDRESS_WIDTH-1:0] CSR_FF_address;
    logic [CSR_DATA_WIDTH-1:0]    CSR_FF_write_data;
    logic [CSR_DATA_WIDTH-1:0]    CSR_FF_read_data;
    logic H2C_tvalid, H2C_tready, H2C_tlast;
    logic C2H_tvalid, C2H_tready, C2H_tlast;

    modport master (
        output CSR_FF_valid, CSR_FF_write_enable, CSR_FF_address, CSR_FF_write_data,
        output H2C_tvalid, H2C_tready, H2C_tlast, C2H_tvalid, C2H_tready, C2H_tlast,
        input  CSR_FF_read_data
    );

    modport slave (
        input  CSR_FF_valid, CSR_FF_write_enable, CSR_FF_address, CSR_FF_write_data,
        input  H2C_tvalid, H2C_tready, H2C_tlast, C2H_tvalid, C2H_tready, C2H_tlast,
        output CSR_FF_read_data
    );
endinterface

// File: rtl/event_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module event_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);
    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i)
            count_d = '0;
        else if (inc_i && !(&count_q))
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count_o = count_q;
endmodule

// File: rtl/csr_register_file.sv
// CSR register file: ID/CONTROL/STATUS/SCRATCH, a 64-bit cycle counter with
// latched high half, and beat/packet monitors on the H2C and C2H streams.
module csr_register_file
    import csr_pkg::*;
#(
    parameter int                        CSR_DATA_WIDTH    = 32,
    parameter int                        CSR_ADDRESS_WIDTH = 8,
    parameter logic [CSR_DATA_WIDTH-1:0] ID_VALUE          = ID_VALUE_DEFAULT
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         CSR_FF_valid,
    input  logic                         CSR_FF_write_enable,
    input  logic [CSR_ADDRESS_WIDTH-1:0] CSR_FF_address,
    input  logic [CSR_DATA_WIDTH-1:0]    CSR_FF_write_data,
    output logic [CSR_DATA_WIDTH-1:0]    CSR_FF_read_data,
    input  logic                         H2C_tvalid,
    input  logic                         H2C_tready,
    input  logic                         H2C_tlast,
    input  logic                         C2H_tvalid,
    input  logic                         C2H_tready,
    input  logic                         C2H_tlast,
    output logic                         control_enable,
    output logic                         soft_reset
);
    typedef logic [CSR_ADDRESS_WIDTH-1:0] addr_t;
    typedef logic [CSR_DATA_WIDTH-1:0]    data_t;

    logic  wr_en, rd_en, ctrl_wr, clear, lo_rd;
    logic  en_q, en_d, sreset_q, sreset_d;
    data_t scratch_q, scratch_d, rdata_q, rdata_d, rd_mux;
    logic [63:0] cycle_q, cycle_d;
    logic [31:0] shadow_q, shadow_d;
    data_t h2c_beats, c2h_beats, h2c_pkts, c2h_pkts;

    assign wr_en   = CSR_FF_valid &&  CSR_FF_write_enable;
    assign rd_en   = CSR_FF_valid && !CSR_FF_write_enable;
    assign ctrl_wr = wr_en && (CSR_FF_address == addr_t'(ADDR_CONTROL));
    assign clear   = ctrl_wr && CSR_FF_write_data[CTRL_SRESET_BIT];
    assign lo_rd   = rd_en && (CSR_FF_address == addr_t'(ADDR_CYCLE_LO));

    event_counter #(.WIDTH(CSR_DATA_WIDTH)) u_h2c_beats (
        .clock(clock), .reset(reset), .clear_i(clear),
        .inc_i(H2C_tvalid && H2C_tready), .count_o(h2c_beats));
    event_counter #(.WIDTH(CSR_DATA_WIDTH)) u_c2h_beats (
        .clock(clock), .reset(reset), .clear_i(clear),
        .inc_i(C2H_tvalid && C2H_tready), .count_o(c2h_beats));
    event_counter #(.WIDTH(CSR_DATA_WIDTH)) u_h2c_pkts (
        .clock(clock), .reset(reset), .clear_i(clear),
        .inc_i(H2C_tvalid && H2C_tready && H2C_tlast), .count_o(h2c_pkts));
    event_counter #(.WIDTH(CSR_DATA_WIDTH)) u_c2h_pkts (
        .clock(clock), .reset(reset), .clear_i(clear),
        .inc_i(C2H_tvalid && C2H_tready && C2H_tlast), .count_o(c2h_pkts));

    always_comb begin
        rd_mux = '0;
        case (CSR_FF_address)
            addr_t'(ADDR_ID):          rd_mux = ID_VALUE;
            addr_t'(ADDR_CONTROL):     rd_mux = data_t'(en_q);
            addr_t'(ADDR_STATUS):      rd_mux = data_t'({sreset_q, en_q});
            addr_t'(ADDR_SCRATCH):     rd_mux = scratch_q;
            addr_t'(ADDR_CYCLE_LO):    rd_mux = data_t'(cycle_q[31:0]);
            addr_t'(ADDR_CYCLE_HI):    rd_mux = data_t'(shadow_q);
            addr_t'(ADDR_H2C_BEATS):   rd_mux = h2c_beats;
            addr_t'(ADDR_C2H_BEATS):   rd_mux = c2h_beats;
            addr_t'(ADDR_H2C_PACKETS): rd_mux = h2c_pkts;
            addr_t'(ADDR_C2H_PACKETS): rd_mux = c2h_pkts;
            default:                   rd_mux = '0;
        endcase
    end

    always_comb begin
        en_d      = en_q;
        sreset_d  = clear;
        scratch_d = scratch_q;
        rdata_d   = rd_en ? rd_mux : rdata_q;
        if (ctrl_wr)
            en_d = CSR_FF_write_data[CTRL_ENABLE_BIT];
        if (wr_en && (CSR_FF_address == addr_t'(ADDR_SCRATCH)))
            scratch_d = CSR_FF_write_data;
        // The read mux samples pre-clear values, so a LO read alongside a
        // clear still returns the old count while the shadow goes to 0.
        if (clear)        cycle_d = '0;
        else if (en_q)    cycle_d = cycle_q + 64'd1;
        else              cycle_d = cycle_q;
        if (clear)        shadow_d = '0;
        else if (lo_rd)   shadow_d = cycle_q[63:32];
        else              shadow_d = shadow_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            en_q      <= 1'b0;
            sreset_q  <= 1'b0;
            scratch_q <= '0;
            rdata_q   <= '0;
            cycle_q   <= '0;
            shadow_q  <= '0;
        end else begin
            en_q      <= en_d;
            sreset_q  <= sreset_d;
            scratch_q <= scratch_d;
            rdata_q   <= rdata_d;
            cycle_q   <= cycle_d;
            shadow_q  <= shadow_d;
        end
    end

    assign CSR_FF_read_data = rdata_q;
    assign control_enable   = en_q;
    assign soft_reset       = sreset_q;
endmodule
